// File: rtl/hdmi_hist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_hist_pkg
// Purpose  : Shared sizes, state encodings and luma helper for the histogram.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_hist_pkg;

    localparam int NUM_BINS     = 256;
    localparam int BIN_ADDR_W   = 8;
    localparam int LUMA_KR_DEF  = 77;
    localparam int LUMA_KG_DEF  = 150;
    localparam int LUMA_KB_DEF  = 29;

    typedef enum logic [2:0] {
        ST_CLR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DUMP  = 3'd4
    } hist_state_t;

    // Per-bin handshake phases while in ST_DUMP
    typedef enum logic [2:0] {
        DP_RD   = 3'd0,
        DP_LAT  = 3'd1,
        DP_HOLD = 3'd2,
        DP_CLR  = 3'd3,
        DP_REL  = 3'd4
    } dump_phase_t;

    function automatic logic [BIN_ADDR_W-1:0] calc_luma(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b,
        input int         kr,
        input int         kg,
        input int         kb
    );
        logic [17:0] s;
        s = 18'(kr) * {10'd0, r} + 18'(kg) * {10'd0, g} + 18'(kb) * {10'd0, b};
        return 8'(s >> 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_hist_ram.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_hist_ram
// Purpose  : Simple dual-port RAM, registered read (read-first on collision).
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_hist_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/hdmi_hist_accum.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_hist_accum
// Purpose  : 256-bin luma histogram per frame with clear-on-read bin dump.
//            Optional HIST_SAT_FLAG_EN adds the hist_sat output.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_hist_accum
    import hdmi_hist_pkg::*;
#(
    parameter int BIN_W   = 16,
    parameter int LUMA_KR = LUMA_KR_DEF,
    parameter int LUMA_KG = LUMA_KG_DEF,
    parameter int LUMA_KB = LUMA_KB_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [7:0]            pix_r,
    input  logic [7:0]            pix_g,
    input  logic [7:0]            pix_b,
    output logic [BIN_W-1:0]      hist_bin_data,
    output logic [BIN_ADDR_W-1:0] hist_bin_addr,
    output logic                  hist_bin_ready,
    input  logic                  hist_bin_saved,
    output logic                  busy,
    output logic [15:0]           drop_cnt
`ifdef HIST_SAT_FLAG_EN
    ,
    output logic                  hist_sat
`endif
);

    localparam logic [BIN_ADDR_W-1:0] C_LAST_BIN = BIN_ADDR_W'(NUM_BINS - 1);

    hist_state_t             r_state, w_state_nxt;
    dump_phase_t             r_phase, w_phase_nxt;
    logic [BIN_ADDR_W-1:0]   r_clr_addr;
    logic [1:0]              r_drain_cnt;
    logic [BIN_ADDR_W-1:0]   r_dump_addr;

    logic                    w_accept;
    logic                    r_l_valid, r_rd_valid, r_wr_valid, r_wr2_valid;
    logic [BIN_ADDR_W-1:0]   r_l_bin, r_rd_bin, r_wr_bin, r_wr2_bin;
    logic [BIN_W-1:0]        r_wr_cnt, r_wr2_cnt;
    logic [BIN_W-1:0]        w_base, w_inc;

    logic                    w_we;
    logic [BIN_ADDR_W-1:0]   w_waddr, w_raddr;
    logic [BIN_W-1:0]        w_wdata, w_rd_data;

    logic [BIN_W-1:0]        r_bin_data;
    logic [BIN_ADDR_W-1:0]   r_bin_addr;
    logic                    r_ready;
    logic [15:0]             r_drop_cnt;

    assign w_accept = pix_valid && (r_state == ST_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLR;
            r_phase <= DP_RD;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            ST_CLR:   if (r_clr_addr == C_LAST_BIN) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (frame_start) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (frame_start) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (r_drain_cnt == 2'd2) begin
                    w_state_nxt = ST_DUMP;
                    w_phase_nxt = DP_RD;
                end
            end
            ST_DUMP: begin
                case (r_phase)
                    DP_RD:   w_phase_nxt = DP_LAT;
                    DP_LAT:  w_phase_nxt = DP_HOLD;
                    DP_HOLD: if (hist_bin_saved) w_phase_nxt = DP_CLR;
                    DP_CLR:  w_phase_nxt = DP_REL;
                    DP_REL: begin
                        if (!hist_bin_saved) begin
                            w_phase_nxt = DP_RD;
                            if (r_dump_addr == C_LAST_BIN) w_state_nxt = ST_ACCUM;
                        end
                    end
                    default: w_phase_nxt = DP_RD;
                endcase
            end
            default: w_state_nxt = ST_CLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_addr  <= '0;
            r_drain_cnt <= '0;
            r_dump_addr <= '0;
        end else begin
            r_clr_addr  <= (r_state == ST_CLR) ? r_clr_addr + 1'b1 : '0;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
            if (r_state != ST_DUMP) begin
                r_dump_addr <= '0;
            end else if (r_phase == DP_REL && !hist_bin_saved && r_dump_addr != C_LAST_BIN) begin
                r_dump_addr <= r_dump_addr + 1'b1;
            end
        end
    end

    // Increment pipeline: L (luma) -> RD (RAM data back) -> WR (write).
    // WR2 covers the read-first collision one cycle further back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_l_valid   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr2_valid <= 1'b0;
            r_l_bin     <= '0;
            r_rd_bin    <= '0;
            r_wr_bin    <= '0;
            r_wr2_bin   <= '0;
            r_wr_cnt    <= '0;
            r_wr2_cnt   <= '0;
        end else begin
            r_l_valid   <= w_accept;
            r_l_bin     <= calc_luma(pix_r, pix_g, pix_b, LUMA_KR, LUMA_KG, LUMA_KB);
            r_rd_valid  <= r_l_valid;
            r_rd_bin    <= r_l_bin;
            r_wr_valid  <= r_rd_valid;
            r_wr_bin    <= r_rd_bin;
            r_wr_cnt    <= w_inc;
            r_wr2_valid <= r_wr_valid;
            r_wr2_bin   <= r_wr_bin;
            r_wr2_cnt   <= r_wr_cnt;
        end
    end

    always_comb begin
        w_base = w_rd_data;
        if (r_wr_valid && r_wr_bin == r_rd_bin) begin
            w_base = r_wr_cnt;
        end else if (r_wr2_valid && r_wr2_bin == r_rd_bin) begin
            w_base = r_wr2_cnt;
        end
        w_inc = (w_base == '1) ? w_base : w_base + BIN_W'(1);
    end

    always_comb begin
        w_we    = r_wr_valid;
        w_waddr = r_wr_bin;
        w_wdata = r_wr_cnt;
        if (r_state == ST_CLR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = '0;
        end else if (r_state == ST_DUMP && r_phase == DP_CLR) begin
            w_we    = 1'b1;
            w_waddr = r_dump_addr;
            w_wdata = '0;
        end
        w_raddr = (r_state == ST_DUMP) ? r_dump_addr : r_l_bin;
    end

    hdmi_hist_ram #(
        .DATA_W (BIN_W),
        .ADDR_W (BIN_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin_data <= '0;
            r_bin_addr <= '0;
            r_ready    <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (r_state == ST_DUMP && r_phase == DP_LAT) begin
                r_bin_data <= w_rd_data;
                r_bin_addr <= r_dump_addr;
                r_ready    <= 1'b1;
            end else if (r_state == ST_DUMP && r_phase == DP_HOLD && hist_bin_saved) begin
                r_ready    <= 1'b0;
            end
            if (pix_valid && r_state != ST_ACCUM && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

`ifdef HIST_SAT_FLAG_EN
    logic r_hist_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist_sat <= 1'b0;
        end else if (r_state == ST_DUMP && w_state_nxt == ST_ACCUM) begin
            r_hist_sat <= 1'b0;
        end else if (r_rd_valid && w_inc == '1) begin
            r_hist_sat <= 1'b1;
        end
    end

    assign hist_sat = r_hist_sat;
`endif

    assign hist_bin_data  = r_bin_data;
    assign hist_bin_addr  = r_bin_addr;
    assign hist_bin_ready = r_ready;
    assign busy           = (r_state == ST_DRAIN) || (r_state == ST_DUMP);
    assign drop_cnt       = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_hist_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_hist_accum
// Purpose  : Scoreboard bench for hdmi_hist_accum (bin dumps vs. pixel model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_hist_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_r = 8'd0, pix_g = 8'd0, pix_b = 8'd0;
    logic [15:0] hist_bin_data;
    logic [7:0]  hist_bin_addr;
    logic        hist_bin_ready;
    logic        hist_bin_saved = 1'b0;
    logic        busy;
    logic [15:0] drop_cnt;
`ifdef HIST_SAT_FLAG_EN
    logic        hist_sat;
    bit          sat_exp = 1'b0;
`endif

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t sb[$];
    int   model[256];
    int   checks = 0;
    int   errors = 0;
    int   exp_drop = 0;
    int   drop_left = 0;

    hdmi_hist_accum dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .pix_valid      (pix_valid),
        .pix_r          (pix_r),
        .pix_g          (pix_g),
        .pix_b          (pix_b),
        .hist_bin_data  (hist_bin_data),
        .hist_bin_addr  (hist_bin_addr),
        .hist_bin_ready (hist_bin_ready),
        .hist_bin_saved (hist_bin_saved),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
`ifdef HIST_SAT_FLAG_EN
        ,
        .hist_sat       (hist_sat)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle; injects queued out-of-frame pixels
    task automatic tick();
        @(negedge clk);
        if (drop_left > 0) begin
            pix_valid = 1'b1;
            pix_r     = 8'd9;
            pix_g     = 8'd77;
            pix_b     = 8'd200;
            drop_left--;
            exp_drop++;
        end else begin
            pix_valid = 1'b0;
        end
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int y;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_r = r;
        pix_g = g;
        pix_b = b;
        y = (77 * int'(r) + 150 * int'(g) + 29 * int'(b)) >> 8;
        if (model[y] < 65535) model[y]++;
    endtask

    task automatic pulse_frame_start();
        @(negedge clk);
        pix_valid   = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic end_frame();
        pulse_frame_start();
        for (int i = 0; i < 256; i++) begin
            sb.push_back('{i, model[i]});
            model[i] = 0;
        end
    endtask

    task automatic check_drop(input string name);
        checks++;
        if (drop_cnt !== 16'(exp_drop)) begin
            $display("FAIL %s: drop_cnt=%0d expected %0d", name, drop_cnt, exp_drop);
            errors++;
        end
    endtask

    // Consume bins with a given ack delay; stop_at<256 triggers mid-dump reset
    task automatic run_dump(input int delay, input int stop_at);
        bit abort = 1'b0;
        for (int b = 0; b < 256 && !abort; b++) begin
            int          n = 0;
            exp_t        e;
            logic [15:0] d0;
            logic [7:0]  a0;
            bit          ok;
            while (!hist_bin_ready && n < 100) begin
                tick();
                n++;
            end
            checks++;
            if (!hist_bin_ready) begin
                $display("FAIL dump_ready bin %0d: ready=0 after %0d cycles, expected 1", b, n);
                errors++;
                abort = 1'b1;
            end else if (b == stop_at) begin
                checks++;
                if (hist_bin_addr !== 8'(b)) begin
                    $display("FAIL abort_addr: addr=%0d expected %0d", hist_bin_addr, b);
                    errors++;
                end
                rst = 1'b1;
                @(negedge clk);
                checks++;
                if (hist_bin_ready !== 1'b0) begin
                    $display("FAIL abort_ready: ready=%b expected 0", hist_bin_ready);
                    errors++;
                end
                rst = 1'b0;
                abort = 1'b1;
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (hist_bin_addr !== 8'(e.addr)) begin
                    $display("FAIL bin_addr: addr=%0d expected %0d", hist_bin_addr, e.addr);
                    errors++;
                end
                if (hist_bin_data !== 16'(e.data)) begin
                    $display("FAIL bin_data[%0d]: data=%0d expected %0d", e.addr, hist_bin_data, e.data);
                    errors++;
                end
                if (b == 0) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        $display("FAIL busy_dump: busy=%b expected 1", busy);
                        errors++;
                    end
`ifdef HIST_SAT_FLAG_EN
                    checks++;
                    if (hist_sat !== sat_exp) begin
                        $display("FAIL hist_sat: hist_sat=%b expected %b", hist_sat, sat_exp);
                        errors++;
                    end
`endif
                end
                d0 = hist_bin_data;
                a0 = hist_bin_addr;
                ok = 1'b1;
                for (int k = 0; k < delay; k++) begin
                    tick();
                    if (hist_bin_data !== d0 || hist_bin_addr !== a0 || hist_bin_ready !== 1'b1) ok = 1'b0;
                end
                if (delay > 0) begin
                    checks++;
                    if (!ok) begin
                        $display("FAIL hold_stable bin %0d: data/addr/ready changed before ack, expected stable", b);
                        errors++;
                    end
                end
                hist_bin_saved = 1'b1;
                n = 0;
                do begin
                    tick();
                    n++;
                end while (hist_bin_ready && n < 100);
                checks++;
                if (hist_bin_ready !== 1'b0) begin
                    $display("FAIL ack_drop bin %0d: ready=%b expected 0", b, hist_bin_ready);
                    errors++;
                    abort = 1'b1;
                end
                if (delay > 0) begin
                    ok = 1'b1;
                    repeat (3) begin
                        tick();
                        if (hist_bin_ready !== 1'b0) ok = 1'b0;
                    end
                    checks++;
                    if (!ok) begin
                        $display("FAIL ready_while_saved bin %0d: ready reasserted, expected 0", b);
                        errors++;
                    end
                end
                hist_bin_saved = 1'b0;
            end
        end
        if (stop_at >= 256 && !abort) begin
            int n = 0;
            while (busy && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (busy !== 1'b0) begin
                $display("FAIL busy_end: busy=%b expected 0", busy);
                errors++;
            end
        end
        hist_bin_saved = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (hist_bin_ready !== 1'b0) begin $display("FAIL rst_ready: %b expected 0", hist_bin_ready); errors++; end
        if (hist_bin_data !== 16'd0) begin $display("FAIL rst_data: %0d expected 0", hist_bin_data); errors++; end
        if (hist_bin_addr !== 8'd0) begin $display("FAIL rst_addr: %0d expected 0", hist_bin_addr); errors++; end
        if (busy !== 1'b0) begin $display("FAIL rst_busy: %b expected 0", busy); errors++; end
        if (drop_cnt !== 16'd0) begin $display("FAIL rst_drop: %0d expected 0", drop_cnt); errors++; end
        rst = 1'b0;
        drop_left = 3;
        repeat (5) tick();
        pulse_frame_start();
        repeat (260) tick();
        check_drop("clr_drops");
    endtask

    task automatic test_basic();
        pulse_frame_start();
        repeat (100) send_pixel(8'd128, 8'd128, 8'd128);
        end_frame();
        run_dump(0, 256);
    endtask

    task automatic test_alternating();
        repeat (50) begin
            send_pixel(8'd255, 8'd0, 8'd0);
            send_pixel(8'd0, 8'd255, 8'd0);
        end
        end_frame();
        run_dump(0, 256);
    endtask

    task automatic test_saturation();
        repeat (70000) send_pixel(8'd0, 8'd0, 8'd0);
        end_frame();
`ifdef HIST_SAT_FLAG_EN
        sat_exp = 1'b1;
`endif
        run_dump(0, 256);
`ifdef HIST_SAT_FLAG_EN
        sat_exp = 1'b0;
`endif
    endtask

    task automatic test_slow_consumer();
        repeat (5) send_pixel(8'd33, 8'd33, 8'd33);
        send_pixel(8'd10, 8'd20, 8'd250);
        end_frame();
        drop_left = 20;
        run_dump(10, 256);
        check_drop("dump_drops");
    endtask

    task automatic test_back_to_back();
        repeat (10) send_pixel(8'd5, 8'd5, 8'd5);
        end_frame();
        run_dump(0, 256);
        repeat (3) send_pixel(8'd5, 8'd5, 8'd5);
        end_frame();
        run_dump(0, 256);
    endtask

    task automatic test_reset_mid_dump();
        repeat (4) send_pixel(8'd60, 8'd60, 8'd60);
        end_frame();
        run_dump(0, 40);
        for (int i = 0; i < 256; i++) model[i] = 0;
        exp_drop = 0;
        check_drop("rst_clears_drop");
        repeat (260) tick();
        pulse_frame_start();
        repeat (7) send_pixel(8'd200, 8'd200, 8'd200);
        end_frame();
        run_dump(0, 256);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 0;
        test_reset();
        test_basic();
        test_alternating();
        test_saturation();
        test_slow_consumer();
        test_back_to_back();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
